wrap_event_monitor: RTL and testbench
=====================================

Name: wrap_event_monitor

Overview:
- Sits directly downstream of the 4-bit free-running down counter and consumes its `out` bus every clock.
- Detects each wrap (0 -> all-ones), emits a one-cycle pulse per wrap, and accumulates wraps.
- Reports the batch count to a consumer over a valid/ready handshake once THRESH wraps have been seen.
- Flags sequence errors: any step that is not a decrement by 1 and not a wrap.

Parameters:
- WIDTH, 4: width of the monitored count bus.
- CNT_W, 8: width of the wrap accumulator and of the reported count.
- THRESH, 4: number of wraps that triggers a report (1 <= THRESH <= 2^CNT_W-1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- count_in  in  WIDTH  down-counter value, sampled every cycle while count_en=1.
- count_en  in  1  sample enable; 0 = ignore count_in and hold history.
- wrap_pulse  out  1  one-cycle pulse, registered, one cycle after the wrapping sample.
- evt_valid  out  1  report available.
- evt_ready  in  1  consumer accepts the report.
- evt_count  out  CNT_W  wraps in this report; stable while evt_valid=1.
- seq_err  out  1  sticky; set on an illegal step.
- sat  out  1  sticky; accumulator saturated.

Behaviour:
- Reset values:
  - all outputs 0;
  - internal prev=0, primed=0, acc=0;
  - FSM=IDLE.
  - Reset mid-handshake drops any pending report.
- History:
  - On count_en=1, prev<=count_in and primed<=1.
  - The first enabled sample after reset only primes; no wrap and no error check.
- Wrap: primed & count_en & prev==0 & count_in==2^WIDTH-1.
  - wrap_pulse=1 on the next cycle only.
  - Latency is exactly 1 clock.
- Legal step: count_in==prev-1 (mod 2^WIDTH; the wrap is included).
  - Equal value (a held counter) is also legal.
  - Any other value with primed & count_en sets seq_err.
  - seq_err clears only on reset.
  - An illegal step never counts as a wrap.
- Accumulator:
  - acc increments by 1 per wrap.
  - At 2^CNT_W-1, acc holds and sets sat.
- FSM:
  - IDLE, when acc (including this cycle's wrap) >= THRESH:
    - evt_count <= that value;
    - acc <= 0;
    - evt_valid <= 1;
    - go to REPORT.
  - REPORT:
    - evt_valid stays 1 and evt_count is held until evt_ready=1.
    - Transfer completes on the cycle where evt_valid & evt_ready are both 1.
    - Next cycle evt_valid=0 and the FSM returns to IDLE.
    - Wraps arriving during REPORT accumulate into acc; none are lost.
    - Back-to-back reports are separated by at least one idle cycle.
  - evt_ready while in IDLE is ignored.
- Simultaneous events:
  - A wrap in the cycle the threshold is crossed is included in the reported value.
  - A wrap in the cycle of the handshake goes into acc.
- Width rules:
  - All arithmetic is unsigned.
  - prev-1 uses WIDTH-bit modular arithmetic.
  - The acc compare uses CNT_W bits.

Decomposition:
- Shared package `counter_pkg`:
  - localparam CNT_MAX = 2^WIDTH-1;
  - FSM state typedef {IDLE, REPORT}.
- One natural sub-module: `step_checker`.
  - Holds prev/primed.
  - Outputs wrap_det and step_err combinationally.
- The FSM, accumulator and handshake stay in the top module.

Test Plan:
- Reset for 1 cycle, then drive 15,14,...,0,15 with count_en=1 -> wrap_pulse=1 exactly one cycle after the 15 sample; seq_err=0; evt_valid=0.
- 4 full wraps with THRESH=4, evt_ready=1 -> evt_valid one cycle for evt_count=4; acc returns to 0.
- Same as above with evt_ready=0 for 40 cycles covering 2 more wraps -> evt_valid held with evt_count=4; after ready, the next report reaches 4 after 2 further wraps (acc=2 carried).
- Drive 9,8,5 -> seq_err=1 one cycle after the 5 and stays 1; no wrap_pulse.
- Drive count_en=0 for 10 cycles with count_in changing randomly, then resume at prev-1 -> no seq_err, no wrap.
- Assert reset while evt_valid=1 -> next cycle evt_valid=0, evt_count=0, seq_err=0, sat=0; the first sample afterwards only primes.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter monitor: counter geometry and report FSM states.
package counter_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_MAX   = (2 ** WIDTH_DEF) - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_t;

endpackage

// File: rtl/wrap_event_monitor_step_checker.sv
// Keeps the previous enabled sample and classifies the current one as wrap, legal step or error.
module step_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_en,
  output logic             wrap_det,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_prev;
  logic             r_primed;
  logic [WIDTH-1:0] w_dec;
  logic             w_check;

  // History register: only enabled samples update it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev   <= ZERO_W;
      r_primed <= 1'b0;
    end else if (count_en) begin
      r_prev   <= count_in;
      r_primed <= 1'b1;
    end
  end

  // Classify the step; a held value is legal, and the modular decrement covers the wrap.
  always_comb begin
    w_dec    = r_prev - ONE_W;
    w_check  = r_primed & count_en;
    wrap_det = w_check & (r_prev == ZERO_W) & (count_in == ONES_W);
    step_err = w_check & (count_in != w_dec) & (count_in != r_prev);
  end

endmodule

// File: rtl/wrap_event_monitor.sv
// Wrap monitor: pulses per wrap, accumulates wraps and reports batches over valid/ready.
module wrap_event_monitor
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_en,
  output logic             wrap_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             seq_err,
  output logic             sat
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ACC_ZRO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic             w_wrap_det;
  logic             w_step_err;
  logic             w_sat_hit;
  logic [CNT_W-1:0] w_acc_sum;
  logic [CNT_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_evt_count_nxt;
  logic             w_evt_valid_nxt;
  state_t           w_state_nxt;

  state_t           r_state;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_evt_valid;
  logic             r_wrap_pulse;
  logic             r_seq_err;
  logic             r_sat;

  step_checker #(.WIDTH(WIDTH)) u_step_checker (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .count_en (count_en),
    .wrap_det (w_wrap_det),
    .step_err (w_step_err)
  );

  // Accumulator including this cycle's wrap; a wrap at full scale is dropped and flags saturation.
  always_comb begin
    w_sat_hit = 1'b0;
    w_acc_sum = r_acc;
    if (w_wrap_det) begin
      if (r_acc == ACC_MAX) begin
        w_sat_hit = 1'b1;
      end else begin
        w_acc_sum = r_acc + ACC_ONE;
      end
    end else begin
      w_acc_sum = r_acc;
    end
  end

  // Report FSM next state; wraps keep accumulating while a report waits for the consumer.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = w_acc_sum;
    w_evt_count_nxt = r_evt_count;
    w_evt_valid_nxt = r_evt_valid;
    case (r_state)
      IDLE: begin
        if (w_acc_sum >= THR) begin
          w_evt_count_nxt = w_acc_sum;
          w_acc_nxt       = ACC_ZRO;
          w_evt_valid_nxt = 1'b1;
          w_state_nxt     = REPORT;
        end else begin
          w_evt_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      REPORT: begin
        if (evt_ready) begin
          w_evt_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_evt_valid_nxt = 1'b1;
          w_state_nxt     = REPORT;
        end
      end
      default: begin
        w_evt_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending report.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= ACC_ZRO;
      r_evt_count  <= ACC_ZRO;
      r_evt_valid  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_seq_err    <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_evt_count  <= w_evt_count_nxt;
      r_evt_valid  <= w_evt_valid_nxt;
      r_wrap_pulse <= w_wrap_det;
      r_seq_err    <= r_seq_err | w_step_err;
      r_sat        <= r_sat | w_sat_hit;
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign evt_valid  = r_evt_valid;
  assign evt_count  = r_evt_count;
  assign seq_err    = r_seq_err;
  assign sat        = r_sat;

endmodule

// File: tb/tb_wrap_event_monitor.sv
// Directed bench for wrap_event_monitor with a behavioural reference model checked every cycle.
module tb_wrap_event_monitor;

  localparam int THRESH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       count_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       wrap_pulse, evt_valid, seq_err, sat;
  logic [7:0] evt_count;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // reference model state, plain integers
  int m_prev, m_acc, m_count, m_total;
  bit m_primed, m_pulse, m_err, m_sat, m_valid, m_wrap, m_bad;

  int cur;
  int wraps_seen;

  always #5 clk = ~clk;

  wrap_event_monitor #(.WIDTH(4), .CNT_W(8), .THRESH(THRESH)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .count_en   (count_en),
    .wrap_pulse (wrap_pulse),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_count  (evt_count),
    .seq_err    (seq_err),
    .sat        (sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs after each clock, derived directly from the wrap/step/report rules.
  always @(posedge clk) begin
    if (reset) begin
      m_prev = 0; m_acc = 0; m_count = 0;
      m_primed = 0; m_pulse = 0; m_err = 0; m_sat = 0; m_valid = 0;
      started = 1'b1;
    end else if (started) begin
      m_wrap = m_primed && count_en && m_prev == 0 && int'(count_in) == 15;
      m_bad  = m_primed && count_en && int'(count_in) != ((m_prev + 15) % 16)
               && int'(count_in) != m_prev;
      m_pulse = m_wrap;
      if (m_bad) m_err = 1;
      if (count_en) begin
        m_prev   = int'(count_in);
        m_primed = 1;
      end
      m_total = m_acc + (m_wrap ? 1 : 0);
      if (m_total > 255) begin
        m_total = 255;
        m_sat   = 1;
      end
      if (!m_valid) begin
        if (m_total >= THRESH) begin
          m_count = m_total;
          m_acc   = 0;
          m_valid = 1;
        end else begin
          m_acc = m_total;
        end
      end else begin
        m_acc = m_total;
        if (evt_ready) m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
      chk("seq_err",    32'(seq_err),    32'(m_err));
      chk("sat",        32'(sat),        32'(m_sat));
      chk("evt_valid",  32'(evt_valid),  32'(m_valid));
      chk("evt_count",  32'(evt_count),  32'(m_count));
    end
  end

  task automatic drive(input bit en, input int v, input bit rdy);
    reset     = 1'b0;
    count_en  = en;
    count_in  = 4'(v);
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    count_en  = 1'b0;
    count_in  = 4'd0;
    evt_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input bit rdy);
    cur = (cur + 15) % 16;
    drive(1'b1, cur, rdy);
  endtask

  task automatic run_until_valid(input bit rdy);
    for (int i = 0; i < 200; i++) begin
      step(rdy);
      wraps_seen += int'(wrap_pulse);
      if (evt_valid) break;
    end
    chk("valid_seen", 32'(evt_valid), 32'd1);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_err",   32'(seq_err),   32'd0);
    chk("rst_sat",   32'(sat),       32'd0);

    // first sample only primes; then a full descent and one wrap
    cur = 15;
    drive(1'b1, cur, 1'b1);
    chk("prime_no_wrap", 32'(wrap_pulse), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b1);
    chk("descent_err", 32'(seq_err), 32'd0);
    step(1'b1);
    chk("wrap_lat1", 32'(wrap_pulse), 32'd1);
    step(1'b1);
    chk("wrap_one_cycle", 32'(wrap_pulse), 32'd0);
    chk("no_report_yet", 32'(evt_valid), 32'd0);

    // three more wraps reach the threshold with the consumer ready
    wraps_seen = 0;
    run_until_valid(1'b1);
    chk("report1_count", 32'(evt_count), 32'd4);
    step(1'b1);
    chk("report1_done", 32'(evt_valid), 32'd0);

    // consumer stalls across two further wraps
    wraps_seen = 0;
    run_until_valid(1'b0);
    chk("report2_count", 32'(evt_count), 32'd4);
    wraps_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      wraps_seen += int'(wrap_pulse);
    end
    chk("hold_valid", 32'(evt_valid), 32'd1);
    chk("hold_count", 32'(evt_count), 32'd4);
    chk("hold_wraps", 32'(wraps_seen), 32'd2);
    step(1'b1);
    chk("handshake_drop", 32'(evt_valid), 32'd0);
    wraps_seen = 0;
    run_until_valid(1'b1);
    chk("carry_count", 32'(evt_count), 32'd4);
    chk("carry_wraps", 32'(wraps_seen), 32'd2);
    step(1'b1);

    // illegal jump 8 -> 5 sets a sticky error
    do_reset();
    drive(1'b1, 9, 1'b1);
    drive(1'b1, 8, 1'b1);
    chk("pre_err", 32'(seq_err), 32'd0);
    drive(1'b1, 5, 1'b1);
    chk("err_set", 32'(seq_err), 32'd1);
    chk("err_no_wrap", 32'(wrap_pulse), 32'd0);
    drive(1'b1, 4, 1'b1);
    drive(1'b1, 3, 1'b1);
    chk("err_sticky", 32'(seq_err), 32'd1);

    // disabled cycles are ignored; held values are legal
    do_reset();
    drive(1'b1, 10, 1'b1);
    drive(1'b1, 9, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, int'($urandom_range(0, 15)), 1'b1);
    drive(1'b1, 8, 1'b1);
    chk("gap_err", 32'(seq_err), 32'd0);
    chk("gap_wrap", 32'(wrap_pulse), 32'd0);
    drive(1'b1, 8, 1'b1);
    chk("hold_legal", 32'(seq_err), 32'd0);
    for (int v = 7; v >= 0; v--) drive(1'b1, v, 1'b1);
    drive(1'b0, 15, 1'b1);
    drive(1'b0, 15, 1'b1);
    chk("disabled_no_wrap", 32'(wrap_pulse), 32'd0);
    drive(1'b1, 15, 1'b1);
    chk("resume_wrap", 32'(wrap_pulse), 32'd1);

    // reset in the middle of a pending report
    do_reset();
    cur = 15;
    drive(1'b1, cur, 1'b0);
    run_until_valid(1'b0);
    do_reset();
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_count", 32'(evt_count), 32'd0);
    chk("mid_rst_err",   32'(seq_err),   32'd0);
    chk("mid_rst_sat",   32'(sat),       32'd0);
    drive(1'b1, 3, 1'b0);
    chk("rst_prime_only", 32'(seq_err), 32'd0);
    drive(1'b1, 2, 1'b0);
    chk("rst_then_legal", 32'(seq_err), 32'd0);

    // saturation: 256 wraps while a report is stalled
    do_reset();
    cur = 15;
    drive(1'b1, cur, 1'b0);
    run_until_valid(1'b0);
    for (int i = 0; i < 255 * 16; i++) step(1'b0);
    chk("sat_at_max", 32'(sat), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0);
    chk("sat_set", 32'(sat), 32'd1);
    step(1'b1);
    chk("gap_after_handshake", 32'(evt_valid), 32'd0);
    step(1'b1);
    chk("sat_report_valid", 32'(evt_valid), 32'd1);
    chk("sat_report_count", 32'(evt_count), 32'd255);
    step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
